rename_retire_queue: RTL
========================

# rename_retire_queue

In-order retirement queue forming the back end of the register-renaming path. Each rename allocation is recorded as an entry (architectural dest, new physical reg, previous physical reg). Entries are marked complete out of order by execution, retired strictly in program order, and on retirement the previous physical register is returned to the free list while the retirement map is updated.

## Interface
- DEPTH, 16, queue entries; power of two, ≥ 2
- ARCH_W, 5, architectural register index width
- PHYS_W, 6, physical register index width
- TAG_W, 4, log2(DEPTH); width of entry tags

Ports:
- clk  input  1  clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- alloc_valid  input  1  rename presents a new entry
- alloc_ready  output  1  queue can accept an entry this cycle
- alloc_arch  input  ARCH_W  architectural destination
- alloc_new_phys  input  PHYS_W  newly mapped physical register
- alloc_old_phys  input  PHYS_W  physical register previously mapped to alloc_arch
- alloc_tag  output  TAG_W  tag assigned to the entry accepted this cycle (= tail index)
- complete_valid  input  1  execution reports an entry finished
- complete_tag  input  TAG_W  tag of finished entry
- flush  input  1  discard all queued entries
- free_valid  output  1  old physical register available for release
- free_phys  output  PHYS_W  register being released
- free_ready  input  1  free list accepts release
- commit_valid  output  1  entry retires this cycle
- commit_arch  output  ARCH_W  retiring architectural register
- commit_phys  output  PHYS_W  retiring physical register (new_phys)
- count  output  TAG_W+1  occupied entries

## Operation
- Circular buffer, head/tail pointers of TAG_W+1 bits (extra wrap bit); empty when equal, full when indices equal and wrap bits differ.
- Per entry: valid, done, arch, new_phys, old_phys.
- Allocate: alloc_valid & alloc_ready writes entry at tail (valid=1, done=0), tail += 1. alloc_ready = !full (no same-cycle bypass through a retire).
- Complete: complete_valid sets done of entry complete_tag only if that entry is valid at the clock edge; otherwise ignored. Completing an already-done entry is harmless.
- Retire candidate: head entry valid & done.
- free_valid = candidate & (arch != 0); free_phys = head old_phys.
- Retire fires when candidate & (arch == 0 | free_ready). Arch x0 entries retire without a free handshake.
- commit_valid = retire fire; commit_arch/commit_phys from head entry. On fire: head entry valid cleared, head += 1.
- One allocation and one retire per cycle max; both may occur in the same cycle (count unchanged).
- Flush: all valid bits cleared, head = tail = 0, count = 0. A retire firing in the flush cycle is considered complete (its free/commit handshake stands); allocation and completion in the flush cycle are discarded.
- Priority at the edge: reset > flush > {alloc, complete, retire}.

## Timing
- Reset (async assert): all valid/done cleared, head = tail = 0. Outputs: alloc_ready=1, alloc_tag=0, count=0, free_valid=0, commit_valid=0, free_phys/commit_arch/commit_phys=0.
- free_valid, commit_valid, alloc_ready and alloc_tag are combinational from registered state plus free_ready; no input-to-output path except free_ready -> commit_valid.
- Earliest retire: cycle after the completing edge. Minimum alloc-to-retire latency is 2 cycles (alloc edge N, complete edge N+1, retire during N+1→N+2).
- free_valid is held stable, with free_phys unchanged, until free_ready (or flush); it is never withdrawn otherwise.
- count updates on the edge: +1 alloc, -1 retire, 0 both.
- Wrap: pointers roll from DEPTH-1 to 0 with wrap-bit toggle; tags repeat after DEPTH allocations.

## Test plan
- Reset mid-operation with 5 entries queued -> immediately count=0, alloc_ready=1, free_valid=0; and after release, first alloc gets tag 0.
- Alloc (arch=3,new=40,old=3), (arch=7,new=41,old=7); complete tag 1 then tag 0 -> no retire until tag 0 done; then free_phys=3/commit_phys=40, next cycle free_phys=7/commit_phys=41.
- Fill 16 entries -> alloc_ready=0 and count=16. A 17th alloc_valid is not accepted. Complete and retire tag 0 -> alloc_ready=1 next cycle; the next alloc gets tag 0 with wrap.
- free_ready held low 4 cycles with head done (arch=9, old=12) -> free_valid=1 and free_phys=12 stable, no commit; free_ready=1 -> single retire.
- Entry with arch=0 done, free_ready=0 -> commit_valid=1, free_valid=0, retires.
- flush with 6 entries while head retires (free_ready=1) -> that retire completes, count=0 next cycle. complete_tag of a flushed entry is ignored.

Source files
------------

// File: rtl/rename_retire_queue.sv
// In-order retirement queue for the rename path: entries complete out of order,
// retire in program order and hand the displaced physical register back.
module rename_retire_queue #(
    parameter int DEPTH  = 16,
    parameter int ARCH_W = 5,
    parameter int PHYS_W = 6,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [ARCH_W-1:0] alloc_arch,
    input  logic [PHYS_W-1:0] alloc_new_phys,
    input  logic [PHYS_W-1:0] alloc_old_phys,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              complete_valid,
    input  logic [TAG_W-1:0]  complete_tag,
    input  logic              flush,
    output logic              free_valid,
    output logic [PHYS_W-1:0] free_phys,
    input  logic              free_ready,
    output logic              commit_valid,
    output logic [ARCH_W-1:0] commit_arch,
    output logic [PHYS_W-1:0] commit_phys,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] PTR_ONE = {{TAG_W{1'b0}}, 1'b1};

    logic [TAG_W:0]    head_q;
    logic [TAG_W:0]    tail_q;
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [ARCH_W-1:0] arch_q [DEPTH];
    logic [PHYS_W-1:0] new_q  [DEPTH];
    logic [PHYS_W-1:0] old_q  [DEPTH];

    logic [TAG_W-1:0] hidx;
    logic [TAG_W-1:0] tidx;
    logic             full;
    logic             cand;
    logic             arch_zero;
    logic             alloc_fire;
    logic             retire;

    assign hidx = head_q[TAG_W-1:0];
    assign tidx = tail_q[TAG_W-1:0];
    assign full = (hidx == tidx) && (head_q[TAG_W] != tail_q[TAG_W]);

    assign alloc_ready = !full;
    assign alloc_tag   = tidx;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign count       = tail_q - head_q;

    // x0 destinations have nothing to return, so they skip the free handshake
    assign cand         = valid_q[hidx] && done_q[hidx];
    assign arch_zero    = (arch_q[hidx] == '0);
    assign retire       = cand && (arch_zero || free_ready);
    assign free_valid   = cand && !arch_zero;
    assign free_phys    = old_q[hidx];
    assign commit_valid = retire;
    assign commit_arch  = arch_q[hidx];
    assign commit_phys  = new_q[hidx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (complete_valid && valid_q[complete_tag]) begin
                done_q[complete_tag] <= 1'b1;
            end
            // tail and head never share an index while both fire
            if (alloc_fire) begin
                valid_q[tidx] <= 1'b1;
                done_q[tidx]  <= 1'b0;
                tail_q        <= tail_q + PTR_ONE;
            end
            if (retire) begin
                valid_q[hidx] <= 1'b0;
                head_q        <= head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                arch_q[i] <= '0;
                new_q[i]  <= '0;
                old_q[i]  <= '0;
            end
        end else if (alloc_fire && !flush) begin
            arch_q[tidx] <= alloc_arch;
            new_q[tidx]  <= alloc_new_phys;
            old_q[tidx]  <= alloc_old_phys;
        end
    end

endmodule
